// File: rtl/float_compare_pipe.sv
// Pipelined IEEE-754 comparator: evaluates one of eight predicates selected per transaction.
// Latency: LATENCY cycles (1..4) from accepted input to out_valid/result/unordered.
// Backpressure: none; ce=0 freezes every stage and holds outputs, throughput 1 pair/cycle.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   ce              clock enable for all pipeline stages
//   in_valid/op/a/b input transaction: predicate select and operands {sign, exp, mant}
//   out_valid       result/unordered carry a transaction this cycle
//   result          predicate outcome
//   unordered       a or b is NaN
module float_compare_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [2:0]             op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  output logic                   result,
  output logic                   unordered
);

  localparam int W = 1 + EXP_W + MAN_W;
  // Registers after the compare stage. LATENCY=1 puts everything before one register.
  localparam int NOUT = (LATENCY == 1) ? 1 : LATENCY - 1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_lat_check
    $error("float_compare_pipe: LATENCY must be in 1..4");
  end

  localparam logic [2:0] OP_LT = 3'd0;
  localparam logic [2:0] OP_LE = 3'd1;
  localparam logic [2:0] OP_EQ = 3'd2;
  localparam logic [2:0] OP_GT = 3'd3;
  localparam logic [2:0] OP_GE = 3'd4;
  localparam logic [2:0] OP_NE = 3'd5;
  localparam logic [2:0] OP_UN = 3'd6;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return ~|x[W-2:0];
  endfunction

  // Sign-magnitude to monotonic unsigned: positives get the top bit set,
  // negatives are inverted so larger magnitude sorts lower.
  function automatic logic [W-1:0] ord_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : {1'b1, x[W-2:0]};
  endfunction

  // ---------------- stage 1: classify and form keys ----------------
  logic         c_un, c_bz;
  logic [W-1:0] c_ka, c_kb;

  assign c_un = is_nan(a) | is_nan(b);
  assign c_bz = is_zero(a) & is_zero(b);
  assign c_ka = ord_key(a);
  assign c_kb = ord_key(b);

  logic         s_vld, s_un, s_bz;
  logic [2:0]   s_op;
  logic [W-1:0] s_ka, s_kb;

  if (LATENCY == 1) begin : g_s1_comb
    assign s_vld = in_valid;
    assign s_op  = op;
    assign s_un  = c_un;
    assign s_bz  = c_bz;
    assign s_ka  = c_ka;
    assign s_kb  = c_kb;
  end else begin : g_s1_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_vld <= 1'b0;
        s_op  <= '0;
        s_un  <= 1'b0;
        s_bz  <= 1'b0;
        s_ka  <= '0;
        s_kb  <= '0;
      end else if (ce) begin
        s_vld <= in_valid;
        s_op  <= op;
        s_un  <= c_un;
        s_bz  <= c_bz;
        s_ka  <= c_ka;
        s_kb  <= c_kb;
      end
    end
  end

  // ---------------- stage 2: magnitude compare and predicate ----------------
  logic k_eq, k_lt, k_gt, ordered, c_res;

  always_comb begin
    // +0 and -0 have different keys but must compare equal.
    k_eq    = s_bz | (s_ka == s_kb);
    k_lt    = ~s_bz & (s_ka < s_kb);
    k_gt    = ~s_bz & (s_ka > s_kb);
    ordered = ~s_un;
    c_res   = 1'b0;
    case (s_op)
      OP_LT:   c_res = ordered & k_lt;
      OP_LE:   c_res = ordered & (k_lt | k_eq);
      OP_EQ:   c_res = ordered & k_eq;
      OP_GT:   c_res = ordered & k_gt;
      OP_GE:   c_res = ordered & (k_gt | k_eq);
      OP_NE:   c_res = s_un | ~k_eq;
      OP_UN:   c_res = s_un;
      default: c_res = ordered;
    endcase
  end

  // ---------------- output register chain ----------------
  logic [NOUT-1:0] p_vld, p_res, p_un;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld <= '0;
      p_res <= '0;
      p_un  <= '0;
    end else if (ce) begin
      p_vld[0] <= s_vld;
      p_res[0] <= c_res;
      p_un[0]  <= s_un;
      for (int i = 1; i < NOUT; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_res[i] <= p_res[i-1];
        p_un[i]  <= p_un[i-1];
      end
    end
  end

  assign out_valid = p_vld[NOUT-1];
  assign result    = p_res[NOUT-1];
  assign unordered = p_un[NOUT-1];

endmodule
